// File: rtl/skid_register_pkg.sv
// Shared definitions for the skid_register elastic stage: state encoding,
// default data width and the registered-state output decode.
package skid_register_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   // The unused encoding 3 reads as an empty stage.
   function automatic logic [1:0] occupancy_of(input state_e s);
      case (s)
         ST_BUSY: return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/skid_register_we_reg.sv
// Plain write-enable register with asynchronous active-high clear, used for
// both the main and the skid storage of skid_register.
module skid_register_we_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (we) begin
         q <= d;
      end
   end

endmodule

// File: rtl/skid_register.sv
// Two-entry elastic register: valid/ready on both sides, outputs decoded only
// from registered state so out_ready never reaches in_ready combinationally.
module skid_register
   import skid_register_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] Din,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Dout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       occupancy
);

   state_e           state_q;
   state_e           state_d;
   logic             acc;
   logic             tak;
   logic             main_we;
   logic             skid_we;
   logic             main_from_skid;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;

   assign occupancy = occupancy_of(state_q);
   assign out_valid = (occupancy != 2'd0);
   assign in_ready  = (occupancy != 2'd2);
   assign Dout      = main_q;

   assign acc = in_valid & in_ready;
   assign tak = out_valid & out_ready;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block gets a default first so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      main_we        = 1'b0;
      skid_we        = 1'b0;
      main_from_skid = 1'b0;
      case (state_q)
         ST_BUSY: begin
            if (acc && tak) begin
               main_we = 1'b1;
            end else if (acc) begin
               skid_we = 1'b1;
               state_d = ST_FULL;
            end else if (tak) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (tak) begin
               main_we        = 1'b1;
               main_from_skid = 1'b1;
               state_d        = ST_BUSY;
            end
         end
         default: begin
            // Empty (and the illegal encoding): only a valid input moves state,
            // so an X on Din while in_valid is low never reaches storage.
            if (acc) begin
               main_we = 1'b1;
               state_d = ST_BUSY;
            end
         end
      endcase
   end

   assign main_d = main_from_skid ? skid_q : Din;

   skid_register_we_reg #(.WIDTH(WIDTH)) u_main (
      .clk (CLK),
      .rst (RST),
      .we  (main_we),
      .d   (main_d),
      .q   (main_q)
   );

   skid_register_we_reg #(.WIDTH(WIDTH)) u_skid (
      .clk (CLK),
      .rst (RST),
      .we  (skid_we),
      .d   (Din),
      .q   (skid_q)
   );

endmodule
